ib_mul_digit_serial: RTL

//  Parametrised digit-serial multiplier: WA x WB product, one DIGIT x DIGIT partial product per cycle.

---
 rtl/ib_mul_digit_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ib_mul_digit_serial.sv
// Digit-serial WA x WB multiplier: one DIGIT x DIGIT partial product per cycle,
// sign handled by magnitude multiply plus a final conditional negate.
module ib_mul_digit_serial #(
  parameter int WA     = 8,
  parameter int WB     = 8,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_start,
  input  logic [WA-1:0]    i_a,
  input  logic [WB-1:0]    i_b,
  output logic [WA+WB-1:0] o_c,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DG  = (DIGIT < 1) ? 1 : DIGIT;
  localparam int NA  = WA / DG;
  localparam int NB  = WB / DG;
  localparam int WC  = WA + WB;
  localparam int IAW = (NA > 1) ? $clog2(NA) : 1;
  localparam int IBW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  generate
    if ((DIGIT < 1) || (WA % DG != 0) || (WB % DG != 0)) begin : g_bad_params
      $error("ib_mul_digit_serial: WA and WB must be multiples of DIGIT, DIGIT >= 1");
    end
  endgenerate

  logic [1:0]      state_q, state_d;
  logic [WA-1:0]   a_mag_q, a_mag_d;
  logic [WB-1:0]   b_mag_q, b_mag_d;
  logic            neg_q, neg_d;
  logic [IAW-1:0]  ia_q, ia_d;
  logic [IBW-1:0]  ib_q, ib_d;
  logic [WC-1:0]   acc_q, acc_d;
  logic [WC-1:0]   c_q, c_d;
  logic            done_q, done_d;

  logic [WA-1:0]   a_abs;
  logic [WB-1:0]   b_abs;
  logic [DG-1:0]   dig_a, dig_b;
  logic [2*DG-1:0] pp;
  logic [WC-1:0]   pp_shifted;
  logic            last_pair;

  // Magnitude of the most-negative value still fits as an unsigned WA/WB-bit value.
  assign a_abs = ((SIGNED != 0) && i_a[WA-1]) ? -i_a : i_a;
  assign b_abs = ((SIGNED != 0) && i_b[WB-1]) ? -i_b : i_b;

  assign dig_a      = DG'(a_mag_q >> (DG * 32'(ia_q)));
  assign dig_b      = DG'(b_mag_q >> (DG * 32'(ib_q)));
  assign pp         = {{DG{1'b0}}, dig_a} * {{DG{1'b0}}, dig_b};
  assign pp_shifted = WC'(pp) << (DG * (32'(ia_q) + 32'(ib_q)));
  assign last_pair  = (ia_q == IAW'(NA - 1)) && (ib_q == IBW'(NB - 1));

  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    ia_d    = ia_q;
    ib_d    = ib_q;
    acc_d   = acc_q;
    c_d     = c_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          neg_d   = (SIGNED != 0) && (i_a[WA-1] ^ i_b[WB-1]);
          ia_d    = '0;
          ib_d    = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + pp_shifted;
        if (last_pair) begin
          ia_d    = '0;
          ib_d    = '0;
          state_d = S_FIN;
        end else if (ia_q == IAW'(NA - 1)) begin
          ia_d = '0;
          ib_d = ib_q + 1'b1;
        end else begin
          ia_d = ia_q + 1'b1;
        end
      end
      S_FIN: begin
        c_d     = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      ia_q    <= '0;
      ib_q    <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign o_c    = c_q;
  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;

endmodule
